muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU; owns the HI/LO register pair. Replaces the single-cycle combinational multiply/divide in the ALU.
- Iterates shift-add (multiply) or restoring (divide) over WIDTH cycles.
- Generates the pipeline stall for dependent HI/LO accesses.
- Sits beside the execute-stage ALU and is driven by decode/execute control.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- start  in  1  launch an operation; sampled only in IDLE.
- op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- rs_val  in  WIDTH  multiplicand / dividend.
- rt_val  in  WIDTH  multiplier / divisor.
- flush  in  1  abort an in-flight operation (branch/exception squash).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- hilo_rd  in  1  MFHI/MFLO present in execute.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when a result lands in HI/LO.
- stall  out  1  hold the pipeline.

Behaviour:
- Reset (async, rst_b=0): state=IDLE, hi=0, lo=0, busy=0, done=0, stall=0, iteration counter=0.
- States:
  - IDLE: start=1 → latch operands and op → CALC, count=0.
  - CALC: one iteration per cycle; count increments; at count=WIDTH-1 → FIX.
  - FIX: sign correction, write HI/LO → IDLE, done=1 in the next cycle.
- Latency: start high in cycle 0 → busy=1 in cycles 1..WIDTH+1 → done=1 and new hi/lo visible in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- Signed ops:
  - Operands converted to magnitudes at start.
  - MULT: product negated if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
- Result placement:
  - Multiply: {hi,lo} = 2*WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero: lo = all ones, hi = rs_val. Full latency still applies.
- Overflow case DIV of most-negative by -1: lo = most-negative, hi = 0; no trap.
- stall = busy & (start | hilo_rd | hi_we | lo_we). Also stall=1 in the FIX cycle when hilo_rd=1.
- start while busy: not accepted; stall holds it until IDLE, where it is accepted the same cycle done=1.
- hi_we/lo_we:
  - Applied in IDLE only.
  - If asserted in the same cycle the FIX result would write (impossible while stall holds them), the FIX result wins.
- flush:
  - In CALC or FIX: → IDLE next cycle; hi/lo unchanged; no done.
  - flush with start in IDLE: start ignored.
- done is never asserted for two consecutive cycles.
- Reset mid-operation: immediate return to IDLE with the reset values listed above.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply: CALC exits to FIX as soon as the remaining unshifted multiplier bits are all zero (checked each cycle, including cycle 1). MULTU with rt_val=1 completes with done in cycle 3.
  - Divide is unaffected.
- Undefined: fixed WIDTH-iteration latency for all ops.

Decomposition:
- Package muldiv_pkg:
  - op enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - state enum (ST_IDLE, ST_CALC, ST_FIX).
  - ITER_W = $clog2(WIDTH).
- Sub-module muldiv_step: purely combinational single iteration of the shift-add or restore-subtract on the partial {acc, q} register pair, selected by op kind. The controller instantiates one copy.

Test Plan:
- MULTU rs=0xFFFF_FFFF, rt=0x0000_0002, start in cycle 0 → done in cycle 34, hi=0x0000_0001, lo=0xFFFF_FFFE; busy=1 in cycles 1..33.
- MULT rs=-7 (0xFFFF_FFF9), rt=3 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. DIV rs=-7, rt=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU rs=100, rt=0 → lo=0xFFFF_FFFF, hi=100, done in cycle 34. DIV rs=0x8000_0000, rt=-1 → lo=0x8000_0000, hi=0.
- hilo_rd=1 asserted in cycle 5 of a running op → stall=1 through cycle 33, stall=0 in cycle 34. A new start held through the busy window is accepted in cycle 34.
- flush in cycle 10 after MULTU start (prior hi=0x11, lo=0x22) → busy=0 in cycle 11, no done, hi=0x11, lo=0x22.
- MTHI wdata=0xABCD in IDLE → hi=0xABCD next cycle. rst_b pulsed low mid-CALC → hi=lo=0, busy=0 immediately. With MULDIV_EARLY_OUT_EN: MULTU rt=1 → done in cycle 3.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types for the multiply/divide sequencer
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int WIDTH_DFLT = 32;
  localparam int ITER_W     = $clog2(WIDTH_DFLT);

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or restoring-divide iteration on {acc, q}
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic           ge;

  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    // remainder gains one dividend bit; it stays below 2*b so W+1 bits suffice
    rem = {acc, q[WIDTH-1]};
    ge  = (rem >= {1'b0, b});
    if (is_div) begin
      acc_nxt = ge ? WIDTH'(rem - {1'b0, b}) : rem[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], ge};
    end else begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once no multiplier bits remain.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   acc, q, b_mag, rs_q;
  logic               div_q, neg_a, neg_b, div0;
  logic [WIDTH-1:0]   acc_nxt, q_nxt;
  logic               in_div, in_signed, last_iter;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  assign in_div    = op_is_div(op_e'(op));
  assign in_signed = op_is_signed(op_e'(op));
  assign rs_mag    = (in_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (in_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  assign busy  = (state != ST_IDLE);
  assign stall = busy & (start | hilo_rd | hi_we | lo_we);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_q),
    .acc     (acc),
    .q       (q),
    .b       (b_mag),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  always_comb begin
    last_iter = (count == LAST);
`ifdef MULDIV_EARLY_OUT_EN
    if (!div_q && ((q_nxt & ({WIDTH{1'b1}} >> (int'(count) + 1))) == '0))
      last_iter = 1'b1;
`endif
  end

  always_comb begin
    prod = {acc, q};
`ifdef MULDIV_EARLY_OUT_EN
    // an early exit leaves the product short of its final alignment
    prod = prod >> (LAST - count);
`endif
    if (neg_a ^ neg_b)
      prod = -prod;
    quo = (neg_a ^ neg_b) ? -q : q;
    rem = neg_a ? -acc : acc;
    if (!div_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div0) begin
      res_hi = rs_q;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      count <= '0;
      acc   <= '0;
      q     <= '0;
      b_mag <= '0;
      rs_q  <= '0;
      div_q <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      div0  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            state <= ST_CALC;
            count <= '0;
            acc   <= '0;
            div_q <= in_div;
            neg_a <= in_signed & rs_val[WIDTH-1];
            neg_b <= in_signed & rt_val[WIDTH-1];
            q     <= in_div ? rs_mag : rt_mag;
            b_mag <= in_div ? rt_mag : rs_mag;
            rs_q  <= rs_val;
            div0  <= (rt_val == '0);
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
            count <= '0;
          end else begin
            acc <= acc_nxt;
            q   <= q_nxt;
            if (last_iter) state <= ST_FIX;
            else           count <= count + CNT_W'(1);
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          count <= '0;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed-vector bench for muldiv_ctrl
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         hilo_rd = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .flush   (flush),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .hilo_rd (hilo_rd),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start in cycle 0 -> cycle in which done is expected
  function automatic int mul_lat(input logic [W-1:0] m);
    int h;
    h = 0;
    for (int i = 0; i < W; i++) if (m[i]) h = i;
    return EARLY ? h + 3 : W + 2;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input int lat);
    int done_at;
    int busy_cnt;
    done_at  = -1;
    busy_cnt = 0;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 100 && done_at < 0; n++) begin
      #1;
      if (busy) busy_cnt++;
      if (done) done_at = n;
      else tick();
    end
    check({tag, "_lat"}, done_at, lat);
    check({tag, "_busy_cycles"}, busy_cnt, lat - 1);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    tick();
    #1;
    check({tag, "_done_single"}, done, 1'b0);
  endtask

  initial begin
    int bad;
    int lat1;
    int c;
    int dn;

    // reset state, with start/hilo_rd asserted to prove stall stays low
    start = 1'b1; hilo_rd = 1'b1;
    tick(); tick();
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    start = 1'b0; hilo_rd = 1'b0;
    rst_b = 1'b1;
    tick();

    // MTHI in IDLE
    wdata = 32'h0000_ABCD; hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    #1;
    check("mthi", hi, 32'h0000_ABCD);

    run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, mul_lat(32'h2));
    run_op("mult_neg",   OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, mul_lat(32'h3));
    run_op("mult_negneg",OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, mul_lat(32'h5));
    run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 2);
    run_op("div_negdvs", OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, W + 2);
    run_op("divu_plain", OP_DIVU,  32'd1000,      32'd7,         32'd6,         32'd142,       W + 2);
    run_op("divu_zero",  OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, W + 2);
    run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, W + 2);
    run_op("multu_one",  OP_MULTU, 32'h0000_1234, 32'h0000_0001, 32'h0000_0000, 32'h0000_1234, mul_lat(32'h1));

    // hilo_rd and a second start held from cycle 5 through the busy window
    lat1 = mul_lat(32'h0001_0000);
    bad = 0;
    op = OP_MULTU; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000; start = 1'b1;
    for (int k = 1; k <= lat1; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 5) begin
        hilo_rd = 1'b1; start = 1'b1; op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd5;
      end
      #1;
      if (k < 5 && stall !== 1'b0) bad++;
      if (k >= 5 && k < lat1 && stall !== 1'b1) bad++;
    end
    check("stall_window", bad, 0);
    check("stall_after", stall, 0);
    check("hold_done", done, 1);
    check("hold_hi", hi, 32'h0000_0001);
    check("hold_lo", lo, 32'h0000_0000);
    tick();
    start = 1'b0; hilo_rd = 1'b0;
    #1;
    check("restart_busy", busy, 1);
    c = 1;
    while (!done && c < 100) begin
      tick();
      c++;
      #1;
    end
    check("restart_lat", c, mul_lat(32'd5));
    check("restart_hi", hi, 32'h0);
    check("restart_lo", lo, 32'd15);
    tick();

    // flush mid-CALC keeps prior HI/LO
    wdata = 32'h11; hi_we = 1'b1;
    tick();
    hi_we = 1'b0; wdata = 32'h22; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    op = OP_MULTU; rs_val = 32'd5; rt_val = 32'h8000_0000; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_busy", busy, 0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) dn++;
    end
    check("flush_no_done", dn, 0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);

    // flush together with start in IDLE
    op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start_idle", busy, 0);

    // asynchronous reset mid-CALC
    op = OP_MULTU; rs_val = 32'd5; rt_val = 32'h8000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #1;
    check("mid_busy", busy, 1);
    rst_b = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    tick();
    rst_b = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
